// File: rtl/core_pkg.sv
// Shared RV32 core definitions: execute-stage control bit positions and
// memory-stage state encoding.
package core_pkg;

  localparam int CTRL_ALU_SRC   = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_MEM_READ  = 3;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_MEM2REG   = 1;
  localparam int CTRL_REG_WRITE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } ms_state_t;

endpackage

// File: rtl/mem_req_fsm.sv
// Memory-stage sequencer: owns the state register and the data-RAM
// request/grant/response handshake.
//
// state | meaning
// IDLE  | empty, ready to accept
// REQ   | dm_req high, waiting for dm_gnt
// RESP  | read granted, waiting for dm_rvalid
// DONE  | payload valid towards write-back
module mem_req_fsm
  import core_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      es_valid_i,
  input  logic      go_mem_i,
  input  logic      is_write_i,
  input  logic      ws_allowin_i,
  input  logic      dm_gnt_i,
  input  logic      dm_rvalid_i,
  output ms_state_t state_o,
  output logic      allowin_o,
  output logic      accept_o,
  output logic      dm_req_o,
  output logic      rdata_en_o
);

  ms_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign allowin_o  = (state_q == IDLE) || ((state_q == DONE) && ws_allowin_i);
  assign accept_o   = es_valid_i && allowin_o;
  assign dm_req_o   = (state_q == REQ);
  assign rdata_en_o = (state_q == RESP) && dm_rvalid_i;
  assign state_o    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_o) state_d = go_mem_i ? REQ : DONE;
      REQ:  if (dm_gnt_i) state_d = is_write_i ? DONE : RESP;
      RESP: if (dm_rvalid_i) state_d = DONE;
      // leaving DONE and accepting the next result share the same edge
      DONE: if (ws_allowin_i) state_d = accept_o ? (go_mem_i ? REQ : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory-access stage: load/store against the data RAM, beq redirect and
// write-back payload. Define MS_ALIGN_CHECK_EN to flag misaligned accesses.
module mem_stage
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        es_valid,
  output logic        ms_allowin,
  input  logic [5:0]  es_ctrl,
  input  logic [31:0] alu_result,
  input  logic [31:0] wr_data,
  input  logic [4:0]  es_rd,
  input  logic        zero,
  input  logic [31:0] nx_pc,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  input  logic        ws_allowin,
  output logic        ms_valid,
  output logic        ms_reg_write,
  output logic [4:0]  ms_rd,
  output logic [31:0] ms_wb_data,
  output logic        ms_excp
);

  ms_state_t   state;
  logic        accept, rdata_en, is_mem_op, misaligned, go_mem;
  logic        mem_write_q, mem2reg_q, reg_write_q;
  logic        br_taken_q, br_taken_d;
  logic [4:0]  rd_q;
  logic [31:0] alu_q, wdata_q, nx_pc_q, rdata_q;
  logic        unused_alu_src;

  assign unused_alu_src = es_ctrl[CTRL_ALU_SRC];
  assign is_mem_op      = es_ctrl[CTRL_MEM_READ] | es_ctrl[CTRL_MEM_WRITE];

`ifdef MS_ALIGN_CHECK_EN
  assign misaligned = is_mem_op & (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  assign go_mem = is_mem_op & ~misaligned;

  mem_req_fsm u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .es_valid_i   (es_valid),
    .go_mem_i     (go_mem),
    .is_write_i   (mem_write_q),
    .ws_allowin_i (ws_allowin),
    .dm_gnt_i     (dm_gnt),
    .dm_rvalid_i  (dm_rvalid),
    .state_o      (state),
    .allowin_o    (ms_allowin),
    .accept_o     (accept),
    .dm_req_o     (dm_req),
    .rdata_en_o   (rdata_en)
  );

  assign br_taken_d = accept & es_ctrl[CTRL_BRANCH] & zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      nx_pc_q     <= '0;
      br_taken_q  <= 1'b0;
    end else begin
      br_taken_q <= br_taken_d;
      if (accept) begin
        mem_write_q <= es_ctrl[CTRL_MEM_WRITE];
        mem2reg_q   <= es_ctrl[CTRL_MEM2REG];
        reg_write_q <= es_ctrl[CTRL_REG_WRITE];
        rd_q        <= es_rd;
        alu_q       <= alu_result;
        wdata_q     <= wr_data;
        nx_pc_q     <= nx_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rdata_q <= '0;
    else if (rdata_en) rdata_q <= dm_rdata;
  end

`ifdef MS_ALIGN_CHECK_EN
  logic excp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      excp_q <= 1'b0;
    else if (accept) excp_q <= misaligned;
  end
  assign ms_excp      = excp_q;
  assign ms_reg_write = reg_write_q & ~excp_q;
  assign dm_addr      = alu_q;
`else
  assign ms_excp      = 1'b0;
  assign ms_reg_write = reg_write_q;
  assign dm_addr      = {alu_q[31:2], 2'b00};
`endif

  assign dm_we      = dm_req & mem_write_q;
  assign dm_wdata   = wdata_q;
  assign br_taken   = br_taken_q;
  assign br_target  = nx_pc_q;
  assign ms_valid   = (state == DONE);
  assign ms_rd      = rd_q;
  assign ms_wb_data = mem2reg_q ? rdata_q : alu_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; write-back payloads are checked by a
// scoreboard monitor decoupled from the stimulus.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        es_valid;
  logic        ms_allowin;
  logic [5:0]  es_ctrl;
  logic [31:0] alu_result;
  logic [31:0] wr_data;
  logic [4:0]  es_rd;
  logic        zero;
  logic [31:0] nx_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        ws_allowin;
  logic        ms_valid;
  logic        ms_reg_write;
  logic [4:0]  ms_rd;
  logic [31:0] ms_wb_data;
  logic        ms_excp;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .es_valid     (es_valid),
    .ms_allowin   (ms_allowin),
    .es_ctrl      (es_ctrl),
    .alu_result   (alu_result),
    .wr_data      (wr_data),
    .es_rd        (es_rd),
    .zero         (zero),
    .nx_pc        (nx_pc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_gnt       (dm_gnt),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .ws_allowin   (ws_allowin),
    .ms_valid     (ms_valid),
    .ms_reg_write (ms_reg_write),
    .ms_rd        (ms_rd),
    .ms_wb_data   (ms_wb_data),
    .ms_excp      (ms_excp)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        excp;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, input logic [31:0] data,
                      input logic excp, input logic chk_data);
    exp_t e;
    e.rd = rd; e.rw = rw; e.data = data; e.excp = excp; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [5:0] ctrl, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic z, input logic [31:0] pc);
    es_valid = 1'b1; es_ctrl = ctrl; alu_result = alu; wr_data = wd;
    es_rd = rd; zero = z; nx_pc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one result, let the accept edge pass, land in cycle 1
  task automatic issue(input logic [5:0] ctrl, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic z, input logic [31:0] pc);
    drive(ctrl, alu, wd, rd, z, pc);
    step();
    es_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && ms_valid && ws_allowin) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 32'(ms_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_rd", 32'(ms_rd), 32'(mon_e.rd));
        chk("sb_reg_write", 32'(ms_reg_write), 32'(mon_e.rw));
        chk("sb_excp", 32'(ms_excp), 32'(mon_e.excp));
        if (mon_e.chk_data) chk("sb_wb_data", ms_wb_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; es_valid = 1'b0; es_ctrl = '0; alu_result = '0; wr_data = '0;
    es_rd = '0; zero = 1'b0; nx_pc = '0; dm_gnt = 1'b0; dm_rvalid = 1'b0;
    dm_rdata = '0; ws_allowin = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_valid", 32'(ms_valid), 32'd0);
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_br_taken", 32'(br_taken), 32'd0);
    chk("rst_wb_data", ms_wb_data, 32'd0);
    chk("rst_reg_write", 32'(ms_reg_write), 32'd0);
    chk("rst_excp", 32'(ms_excp), 32'd0);
    step();
    rst_n = 1'b1; ws_allowin = 1'b1;

    // ALU op
    push(5'd5, 1'b1, 32'h1234, 1'b0, 1'b1);
    issue(6'b000001, 32'h1234, 32'h0, 5'd5, 1'b0, 32'h0);
    @(negedge clk);
    chk("alu_valid", 32'(ms_valid), 32'd1);
    chk("alu_no_req", 32'(dm_req), 32'd0);
    step();

    // load, grant in cycle 3, rvalid in cycle 4, stray rvalid in cycle 1
    push(5'd7, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(6'b001011, 32'h40, 32'h0, 5'd7, 1'b0, 32'h0);
    dm_rvalid = 1'b1; dm_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("ld_req1", 32'(dm_req), 32'd1);
    chk("ld_addr", dm_addr, 32'h40);
    chk("ld_we", 32'(dm_we), 32'd0);
    chk("ld_stall1", 32'(ms_allowin), 32'd0);
    step();
    dm_rvalid = 1'b0;
    @(negedge clk);
    chk("ld_req2", 32'(dm_req), 32'd1);
    chk("ld_stall2", 32'(ms_allowin), 32'd0);
    step();
    dm_gnt = 1'b1;
    @(negedge clk);
    chk("ld_req3", 32'(dm_req), 32'd1);
    chk("ld_stall3", 32'(ms_allowin), 32'd0);
    step();
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_resp_noreq", 32'(dm_req), 32'd0);
    chk("ld_stall4", 32'(ms_allowin), 32'd0);
    chk("ld_not_valid4", 32'(ms_valid), 32'd0);
    step();
    dm_rvalid = 1'b0; dm_rdata = '0;
    @(negedge clk);
    chk("ld_valid5", 32'(ms_valid), 32'd1);
    step();

    // store, grant delayed to cycle 3
    push(5'd3, 1'b0, 32'h80, 1'b0, 1'b1);
    issue(6'b000100, 32'h80, 32'hA5A5A5A5, 5'd3, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dm_gnt = 1'b1;
      @(negedge clk);
      chk("st_req", 32'(dm_req), 32'd1);
      chk("st_we", 32'(dm_we), 32'd1);
      chk("st_addr", dm_addr, 32'h80);
      chk("st_wdata", dm_wdata, 32'hA5A5A5A5);
      chk("st_stall", 32'(ms_allowin), 32'd0);
      step();
    end
    dm_gnt = 1'b0;
    @(negedge clk);
    chk("st_valid", 32'(ms_valid), 32'd1);
    chk("st_no_req", 32'(dm_req), 32'd0);
    step();

    // beq taken then not taken
    push(5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    issue(6'b010000, 32'h0, 32'h0, 5'd0, 1'b1, 32'h200);
    @(negedge clk);
    chk("br_pulse", 32'(br_taken), 32'd1);
    chk("br_target", br_target, 32'h200);
    step();
    @(negedge clk);
    chk("br_pulse_end", 32'(br_taken), 32'd0);
    push(5'd0, 1'b0, 32'h4, 1'b0, 1'b1);
    issue(6'b010000, 32'h4, 32'h0, 5'd0, 1'b0, 32'h300);
    @(negedge clk);
    chk("br_not_taken", 32'(br_taken), 32'd0);
    chk("br_nt_valid", 32'(ms_valid), 32'd1);
    step();

    // back-pressure for 3 cycles, then back-to-back accept
    ws_allowin = 1'b0;
    push(5'd9, 1'b1, 32'h1111, 1'b0, 1'b1);
    issue(6'b000001, 32'h1111, 32'h0, 5'd9, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(ms_valid), 32'd1);
      chk("bp_data", ms_wb_data, 32'h1111);
      chk("bp_rd", 32'(ms_rd), 32'd9);
      chk("bp_allowin", 32'(ms_allowin), 32'd0);
      step();
    end
    ws_allowin = 1'b1;
    push(5'd10, 1'b1, 32'h2222, 1'b0, 1'b1);
    drive(6'b000001, 32'h2222, 32'h0, 5'd10, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b_allowin", 32'(ms_allowin), 32'd1);
    step();
    es_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 32'(ms_valid), 32'd1);
    chk("b2b_data", ms_wb_data, 32'h2222);
    step();

    // misaligned load
`ifdef MS_ALIGN_CHECK_EN
    push(5'd4, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(6'b001011, 32'h42, 32'h0, 5'd4, 1'b0, 32'h0);
    @(negedge clk);
    chk("al_valid", 32'(ms_valid), 32'd1);
    chk("al_excp", 32'(ms_excp), 32'd1);
    chk("al_no_req", 32'(dm_req), 32'd0);
    chk("al_reg_write", 32'(ms_reg_write), 32'd0);
    step();
`else
    push(5'd4, 1'b1, 32'h0BADF00D, 1'b0, 1'b1);
    issue(6'b001011, 32'h43, 32'h0, 5'd4, 1'b0, 32'h0);
    dm_gnt = 1'b1;
    @(negedge clk);
    chk("al_req", 32'(dm_req), 32'd1);
    chk("al_addr_forced", dm_addr, 32'h40);
    chk("al_excp_tied", 32'(ms_excp), 32'd0);
    step();
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h0BADF00D;
    step();
    dm_rvalid = 1'b0; dm_rdata = '0;
    @(negedge clk);
    chk("al_valid", 32'(ms_valid), 32'd1);
    step();
`endif

    // reset while in REQ, then a late rvalid
    issue(6'b001011, 32'h100, 32'h0, 5'd6, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_pre_req", 32'(dm_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_drop", 32'(dm_req), 32'd0);
    chk("rst_mid_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_mid_valid", 32'(ms_valid), 32'd0);
    step();
    rst_n = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late_rv_valid", 32'(ms_valid), 32'd0);
    chk("late_rv_allowin", 32'(ms_allowin), 32'd1);
    step();
    dm_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rv_valid2", 32'(ms_valid), 32'd0);
    chk("late_rv_wb_data", ms_wb_data, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the RV32 core. It sits between the execute stage and write-back. It accepts one execute-stage result per handshake and performs the load or store against the data RAM through a request/grant/response interface. It also resolves the `beq` redirect and presents the register write-back payload to the write-back stage, stalling upstream while a data-RAM access is outstanding.

## Interface
- Parameters: none; all widths are fixed at RV32.
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `es_valid`  in  1  execute stage holds a valid result
- `ms_allowin`  out  1  this stage can accept the execute result this cycle
- `es_ctrl`  in  6  {alu_src_op, branch, mem_read, mem_write, mem2reg, reg_write}; bit 5 is ignored here
- `alu_result`  in  32  memory address, or the ALU write-back value
- `wr_data`  in  32  store data
- `es_rd`  in  5  destination register
- `zero`  in  1  ALU zero flag
- `nx_pc`  in  32  branch target
- `br_taken`  out  1  one-cycle redirect pulse
- `br_target`  out  32  redirect PC, valid while `br_taken` is high
- `dm_req`  out  1  data-RAM request
- `dm_we`  out  1  1 = write, 0 = read
- `dm_addr`  out  32  word address
- `dm_wdata`  out  32  store data
- `dm_gnt`  in  1  request accepted
- `dm_rvalid`  in  1  read data valid
- `dm_rdata`  in  32  read data
- `ws_allowin`  in  1  write-back stage can accept
- `ms_valid`  out  1  write-back payload valid
- `ms_reg_write`  out  1  register-file write enable
- `ms_rd`  out  5  destination register
- `ms_wb_data`  out  32  write-back value
- `ms_excp`  out  1  misaligned-access flag (see Configuration)

## Operation
- **Accept:** the stage accepts on `es_valid && ms_allowin` at a rising edge. On accept it registers ctrl, `alu_result`, `wr_data`, `es_rd`, `nx_pc` and the condition `branch && zero`.
- **States:** IDLE, REQ, RESP, DONE.
  - IDLE: on accept, go to REQ if mem_read or mem_write is set, otherwise go to DONE.
  - REQ: `dm_req` = 1, and `dm_we`/`dm_addr`/`dm_wdata` are driven from the registers and held stable until `dm_gnt`. On `dm_gnt`, a write goes to DONE and a read goes to RESP.
  - RESP: on `dm_rvalid`, capture `dm_rdata` and go to DONE.
  - DONE: `ms_valid` = 1. On `ws_allowin`, go to REQ or DONE if a new accept happens in the same cycle, otherwise go to IDLE.
- **ms_allowin** = (state == IDLE) || (state == DONE && ws_allowin). This is the back-to-back case: leave and accept in the same cycle.
- **Write-back data:**
  - `ms_wb_data` = the captured read data if mem2reg is set, else `alu_result`.
  - `ms_reg_write` = the registered reg_write bit.
  - `ms_rd` = the registered `es_rd`.
- **Read responses:** `dm_rvalid` is ignored in any state other than RESP. The earliest legal response is the cycle after `dm_gnt`.
- **Branch redirect:** `br_taken` pulses high for exactly one cycle, the cycle after accept, if branch && zero. `br_target` carries the registered `nx_pc`. The pulse is independent of memory state.
- **Word access only:** `dm_addr` is driven from `alu_result`.

## Timing
- **Reset values:** state = IDLE; every output = 0 except `ms_allowin` = 1. Reset asserted mid-access drops `dm_req` asynchronously and abandons the access. A late `dm_rvalid` after reset is ignored.
- **Latencies (accept edge at cycle 0):**
  - Non-memory instruction: `ms_valid` is high in cycle 1.
  - Store with same-cycle grant: `dm_req` high in cycle 1, `ms_valid` high in cycle 2.
  - Load with grant in cycle 1 and rvalid in cycle 2: `ms_valid` high in cycle 3.
- **Stall:** while in REQ or RESP, `ms_allowin` = 0. In DONE with `ws_allowin` = 0, the payload is held stable.

## Configuration
- **`MS_ALIGN_CHECK_EN` defined:** a memory op with `alu_result[1:0]` != 0 skips REQ and goes straight to DONE. In that case `ms_excp` = 1, `ms_reg_write` = 0, and no `dm_req` is issued.
- **`MS_ALIGN_CHECK_EN` undefined:** `dm_addr[1:0]` is forced to 0 and `ms_excp` is tied to 0.

## Structure
- **Shared package `core_pkg`:**
  - es_ctrl bit-index constants: CTRL_ALU_SRC = 5 … CTRL_REG_WRITE = 0.
  - ms_state_t enum: IDLE, REQ, RESP, DONE.
- **Sub-module `mem_req_fsm`:** holds the state register and the dm_req/gnt/rvalid handshake. It exports state and the read-data capture enable. `mem_stage` keeps the payload registers.

## Test plan
- **ALU op:** `es_ctrl` = 6'b000001, `alu_result` = 0x1234, `ws_allowin` = 1 → `ms_valid` the next cycle, `ms_wb_data` = 0x1234, `ms_reg_write` = 1, no `dm_req`.
- **Load:** address 0x40, `dm_gnt` delayed 2 cycles, `dm_rvalid` 1 cycle later with 0xDEADBEEF → `ms_allowin` = 0 throughout. `ms_wb_data` = 0xDEADBEEF on `ms_valid` at cycle 5.
- **Store:** `wr_data` = 0xA5A5A5A5 to address 0x80 → `dm_we` = 1, stable until `dm_gnt`. `ms_valid` follows with `ms_reg_write` = 0.
- **beq:** branch with `zero` = 1 and `nx_pc` = 0x200 → `br_taken` is a one-cycle pulse with `br_target` = 0x200. With `zero` = 0 → no pulse.
- **Back-pressure and back-to-back:** `ws_allowin` = 0 for 3 cycles → payload held. Raise `ws_allowin` with the next `es_valid` → new instruction accepted in the same cycle, no bubble.
- **Reset and alignment:** `rst_n` low while in REQ → `dm_req` drops immediately and state is IDLE. With `MS_ALIGN_CHECK_EN`, a load at 0x42 → `ms_excp` = 1 and no `dm_req`.
